// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding/hazard unit.
// Operand-mux select encodings and the hard-wired zero register index.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam int ZERO_REG = 31;

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// One operand's forwarding match and priority logic.
// The EX-slot producer is newer than the MEM-slot producer, so it wins.
module fwd_src_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_ex_valid,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_valid,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_mem_rd,
  output logic [1:0]        o_sel,
  output logic              o_load_hit
);

  localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(ZERO_REG);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = i_use && i_ex_valid && i_ex_reg_write &&
                       (i_ex_rd != ZERO_RD) && (i_src == i_ex_rd);
  assign w_mem_match = i_use && i_mem_valid && i_mem_reg_write &&
                       (i_mem_rd != ZERO_RD) && (i_src == i_mem_rd);

  // A load in EX has no data yet: it cannot forward, it can only stall.
  assign o_load_hit = w_ex_match && i_ex_mem_read;

  always_comb begin
    o_sel = FWD_REG;
    if (w_ex_match && !i_ex_mem_read) begin
      o_sel = FWD_MEM;
    end else if (w_mem_match) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with shadow EX/MEM slots.
// Selects are registered into EX alongside the operands; stall is combinational.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;

  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_reg_write;
  logic              r_mem_mem_read;

  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [1:0]        w_sel_a;
  logic [1:0]        w_sel_b;
  logic              w_load_hit_a;
  logic              w_load_hit_b;
  logic              w_stall;
  logic              w_bubble;

  fwd_src_sel #(.REG_AW(REG_AW)) u_sel_rn (
    .i_use           (id_use_rn),
    .i_src           (id_rn),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_write  (r_ex_reg_write),
    .i_ex_mem_read   (r_ex_mem_read),
    .i_ex_rd         (r_ex_rd),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_rd        (r_mem_rd),
    .o_sel           (w_sel_a),
    .o_load_hit      (w_load_hit_a)
  );

  fwd_src_sel #(.REG_AW(REG_AW)) u_sel_rm (
    .i_use           (id_use_rm),
    .i_src           (id_rm),
    .i_ex_valid      (r_ex_valid),
    .i_ex_reg_write  (r_ex_reg_write),
    .i_ex_mem_read   (r_ex_mem_read),
    .i_ex_rd         (r_ex_rd),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_rd        (r_mem_rd),
    .o_sel           (w_sel_b),
    .o_load_hit      (w_load_hit_b)
  );

  // A redirect kills the ID instruction anyway, so it never needs to wait.
  assign w_stall  = id_valid && !flush && (w_load_hit_a || w_load_hit_b);
  assign w_bubble = w_stall || flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_rd        <= '0;
      r_mem_reg_write <= 1'b0;
      r_mem_mem_read  <= 1'b0;
      r_fwd_a         <= FWD_REG;
      r_fwd_b         <= FWD_REG;
    end else begin
      r_mem_valid     <= r_ex_valid;
      r_mem_rd        <= r_ex_rd;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_mem_read  <= r_ex_mem_read;
      if (w_bubble) begin
        r_ex_valid     <= 1'b0;
        r_ex_rd        <= '0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
        r_fwd_a        <= FWD_REG;
        r_fwd_b        <= FWD_REG;
      end else begin
        r_ex_valid     <= id_valid;
        r_ex_rd        <= id_rd;
        r_ex_reg_write <= id_reg_write;
        r_ex_mem_read  <= id_mem_read;
        r_fwd_a        <= w_sel_a;
        r_fwd_b        <= w_sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // A load sitting in MEM forwards its WB data like any ALU result, so its
  // load flag only rides along with the slot.
  logic w_unused_mem_read;
  assign w_unused_mem_read = r_mem_mem_read;

  assign stall     = w_stall;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed pipeline scenarios plus random
// traffic, checked against a history-of-issued-instructions reference model.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rn = '0;
  logic [REG_AW-1:0] id_rm = '0;
  logic              id_use_rn = 1'b0;
  logic              id_use_rm = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_reg_write = 1'b0;
  logic              id_mem_read = 1'b0;
  logic              flush = 1'b0;
  logic              stall;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_use_rn    (id_use_rn),
    .id_use_rm    (id_use_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  typedef struct {
    int st;
    int fa;
    int fb;
    int cnt;
  } exp_t;

  instr_t hist[$];   // hist[0]: instruction now in EX, hist[1]: now in MEM
  exp_t   sbq[$];
  int     m_cnt;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 1'b0; b.rd = 0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(bubble());
    hist.push_back(bubble());
    m_cnt = 0;
  endtask

  // Newest earlier producer of src decides; a load one ahead cannot supply data.
  function automatic int ref_sel(input bit use_src, input int src);
    if (!use_src || src == 31) return 0;
    if (hist[0].valid && hist[0].rw && hist[0].rd == src && !hist[0].mr) return 1;
    if (hist[1].valid && hist[1].rw && hist[1].rd == src) return 2;
    return 0;
  endfunction

  function automatic bit ref_load_use(input bit v, input int rn, input int rm,
                                      input bit urn, input bit urm);
    if (!v || !hist[0].valid || !hist[0].mr || !hist[0].rw || hist[0].rd == 31) return 1'b0;
    return (urn && rn == hist[0].rd) || (urm && rm == hist[0].rd);
  endfunction

  task automatic issue(input bit v, input int rn, input int rm, input bit urn,
                       input bit urm, input int rd, input bit rw, input bit mr,
                       input bit fl, output bit st);
    exp_t   e;
    instr_t n;
    @(negedge clk);
    id_valid = v; id_rn = REG_AW'(rn); id_rm = REG_AW'(rm);
    id_use_rn = urn; id_use_rm = urm; id_rd = REG_AW'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    st = !fl && ref_load_use(v, rn, rm, urn, urm);
    e.st = st;
    e.fa = (fl || st) ? 0 : ref_sel(urn, rn);
    e.fb = (fl || st) ? 0 : ref_sel(urm, rm);
    if (fl || st) n = bubble();
    else begin
      n.valid = v; n.rd = rd; n.rw = rw; n.mr = mr;
      if (!v) n = bubble();
    end
    hist.push_front(n);
    while (hist.size() > 2) void'(hist.pop_back());
    if (st && m_cnt < CNT_MAX) m_cnt++;
    e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  // Re-present a stalled instruction until it is accepted, as the frozen ID stage would.
  task automatic instr(input int rn, input int rm, input bit urn, input bit urm,
                       input int rd, input bit rw, input bit mr, input bit fl);
    bit st;
    int tries = 0;
    do begin
      issue(1'b1, rn, rm, urn, urm, rd, rw, mr, fl, st);
      tries++;
    end while (st && tries < 4);
    if (st) chk("stall_released", 1, 0);
  endtask

  task automatic nop();
    bit st;
    issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, st);
  endtask

  function automatic int rreg();
    int r = int'($urandom_range(0, 4));
    return (r == 4) ? 31 : r + 1;
  endfunction

  // Monitor: stall is judged with the cycle's inputs settled, the registered
  // outputs just after the edge that consumes them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", int'(stall), e.st);
        @(posedge clk);
        #1;
        chk("fwd_a", int'(fwd_a), e.fa);
        chk("fwd_b", int'(fwd_b), e.fb);
        chk("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit st;
    model_reset();
    #12;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd_a", int'(fwd_a), 0);
    chk("reset_fwd_b", int'(fwd_b), 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU result forwarded from MEM stage
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    instr(1, 3, 1, 1, 2, 1, 0, 0);
    nop(); nop();
    // ALU result forwarded from WB stage across a NOP
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    nop();
    instr(5, 1, 1, 1, 4, 1, 0, 0);
    nop(); nop();
    // load-use: one stall then WB forwarding on both operands
    instr(7, 0, 1, 0, 1, 1, 1, 0);
    instr(1, 1, 1, 1, 2, 1, 0, 0);
    nop(); nop();
    chk("cnt_after_load_use", int'(stall_cnt), 1);
    // zero register never forwards or stalls
    instr(0, 0, 0, 0, 31, 1, 0, 0);
    instr(31, 31, 1, 1, 2, 1, 0, 0);
    instr(7, 0, 1, 0, 31, 1, 1, 0);
    instr(31, 31, 1, 1, 3, 1, 0, 0);
    nop(); nop();
    // newer producer wins; then the same shape killed by a flush
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    instr(1, 1, 1, 1, 2, 1, 0, 0);
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    instr(0, 0, 0, 0, 1, 1, 0, 0);
    instr(1, 1, 1, 1, 2, 1, 0, 1);
    nop(); nop();

    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 7) != 0), rreg(), rreg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rreg(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), st);
    end

    // load chain into itself: every other cycle stalls, long enough to saturate
    for (int i = 0; i < 2 * (CNT_MAX + 4) + 20; i++) begin
      issue(1'b1, 1, 0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, st);
    end
    chk("cnt_saturated", int'(stall_cnt), CNT_MAX);
    nop(); nop();
    while (sbq.size() > 0) @(posedge clk);
    @(posedge clk);
    #2;

    // asynchronous reset in the middle of a load-use stall
    @(negedge clk);
    id_valid = 1'b1; id_rn = 5'd7; id_rm = 5'd0; id_use_rn = 1'b1; id_use_rm = 1'b0;
    id_rd = 5'd1; id_reg_write = 1'b1; id_mem_read = 1'b1; flush = 1'b0;
    @(negedge clk);
    id_rn = 5'd1; id_rm = 5'd1; id_use_rm = 1'b1; id_rd = 5'd2; id_mem_read = 1'b0;
    #1;
    chk("pre_reset_stall", int'(stall), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_stall", int'(stall), 0);
    chk("async_reset_fwd_a", int'(fwd_a), 0);
    chk("async_reset_fwd_b", int'(fwd_b), 0);
    chk("async_reset_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    // the consumer left in ID sees an empty pipeline
    issue(1'b1, 1, 1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, st);
    for (int i = 0; i < 60; i++) begin
      issue(($urandom_range(0, 7) != 0), rreg(), rreg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rreg(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), st);
    end
    nop();
    while (sbq.size() > 0) @(posedge clk);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_rn, id_rm  input  REG_AW each  ID source register addresses.
REQ-007 id_use_rn, id_use_rm  input  1 each  instruction reads rn / rm.
REQ-008 id_rd  input  REG_AW  ID destination register.
REQ-009 id_reg_write  input  1  ID instruction writes rd.
REQ-010 id_mem_read  input  1  ID instruction is a load.
REQ-011 flush  input  1  branch redirect; kill the instruction entering EX.
REQ-012 stall  output  1  combinational; freeze PC/IF/ID and inject an EX bubble.
REQ-013 fwd_a, fwd_b  output  2 each  registered operand-mux selects for EX (drive the 2:1 mux tree).
REQ-014 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 Select encoding SHALL be: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write data, 11 unused/never driven.
REQ-016 Unit SHALL keep shadow EX and MEM slots, each with {valid, rd, reg_write, mem_read}.
REQ-017 Each cycle without stall or flush: EX slot <= ID fields (valid = id_valid); MEM slot <= EX slot.
REQ-018 When stall=1: MEM slot <= EX slot; EX slot <= bubble (valid=0); ID fields are not captured.
REQ-019 When flush=1: EX slot <= bubble; MEM slot <= EX slot; flush SHALL take priority over stall.
REQ-020 stall SHALL be 1 iff id_valid and EX.valid and EX.mem_read and EX.reg_write and EX.rd != 31 and ((id_use_rn and id_rn==EX.rd) or (id_use_rm and id_rm==EX.rd)), and flush=0.
REQ-021 Selects SHALL be computed in ID per operand and registered into EX on the same edge as the EX slot (1-cycle latency, aligned with operands).
REQ-022 Per operand: 01 if source used, matches EX.rd, EX.valid, EX.reg_write, not EX.mem_read, rd != 31; else 10 if it matches MEM.rd with MEM.valid, MEM.reg_write, rd != 31; else 00.
REQ-023 Newer producer (EX slot) SHALL take priority over older (MEM slot) when both match.
REQ-024 Register 31 (zero register) SHALL never be forwarded nor cause a stall.
REQ-025 On stall or flush the registered selects SHALL load 00.
REQ-026 stall_cnt SHALL increment by 1 on every edge where stall=1 and saturate at all-ones.
REQ-027 Back-to-back loads with dependent consumers SHALL each produce exactly one stall cycle.

Reset
REQ-028 reset_n low SHALL asynchronously clear both slots (valid=0), fwd_a=fwd_b=00, stall_cnt=0; stall therefore reads 0.
REQ-029 Reset asserted mid-stall SHALL drop stall immediately; first post-reset cycle behaves as an empty pipeline.

Structure
REQ-030 Select encodings FWD_REG/FWD_MEM/FWD_WB and ZERO_REG=31 SHALL live in the shared pipeline package.
REQ-031 One sub-module fwd_src_sel (one operand's match/priority logic) SHALL be instantiated twice, for rn and rm.

Verification
REQ-032 ADD X1 then ADD X2,X1,X3 back-to-back -> fwd_a=01 in consumer EX cycle, stall never 1.
REQ-033 ADD X1; NOP; SUB X4,X5,X1 -> fwd_b=10, stall=0.
REQ-034 LDUR X1; ADD X2,X1,X1 -> stall=1 for exactly one cycle, then fwd_a=fwd_b=10, stall_cnt=1.
REQ-035 ADD X31; ADD X2,X31,X31 and LDUR X31 consumer -> selects 00, no stall.
REQ-036 ADD X1 (MEM) and ADD X1 (EX) both ahead of consumer -> select 01 (newer wins); with flush asserted same cycle -> EX bubble, selects 00, stall 0.
REQ-037 Drive reset_n low during a load-use stall -> stall, fwd_a, fwd_b, stall_cnt all 0 before next edge; force 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones.
